// File: rtl/tinker_fetch_unit.sv
// Tinker instruction fetch stage: owns the fetch PC and buffers fetched words with
// their PCs in a prefetch FIFO feeding decode over valid/ready; handles halt and redirect.
module tinker_fetch_unit #(
  parameter int unsigned DEPTH    = 4,
  parameter logic [63:0] RESET_PC = 64'h2000
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       redirect_valid,
  input  logic [63:0]                redirect_pc,
  output logic [63:0]                imem_addr,
  input  logic [31:0]                imem_rdata,
  input  logic                       imem_ready,
  output logic                       id_valid,
  output logic [63:0]                id_pc,
  output logic [31:0]                id_instr,
  input  logic                       id_ready,
  output logic                       fetch_stopped,
  output logic                       halted,
  output logic [$clog2(DEPTH):0]     occupancy
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = PW + 1;

  logic [63:0]   fetch_pc;
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic [CW-1:0] count;
  logic [63:0]   slot_pc    [DEPTH];
  logic [31:0]   slot_instr [DEPTH];
  logic          stopped_q;
  logic          halted_q;
  logic          pop_c;
  logic          push_c;
  logic          not_empty_c;

  function automatic logic is_halt(input logic [31:0] w);
    return (w[31:27] == 5'h0f) && (w[3:0] == 4'h0);
  endfunction

  // Head presentation and handshake qualifiers
  always_comb begin
    not_empty_c = (count != '0);
    id_valid    = not_empty_c & ~redirect_valid;
    id_pc       = not_empty_c ? slot_pc[rd_ptr]    : 64'd0;
    id_instr    = not_empty_c ? slot_instr[rd_ptr] : 32'd0;
    pop_c       = id_valid & id_ready;
    push_c      = ~redirect_valid & ~stopped_q & imem_ready &
                  ((count < CW'(DEPTH)) | pop_c);
  end

  assign imem_addr     = fetch_pc;
  assign occupancy     = count;
  assign fetch_stopped = stopped_q;
  assign halted        = halted_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      fetch_pc  <= RESET_PC;
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      stopped_q <= 1'b0;
      halted_q  <= 1'b0;
      for (int i = 0; i < int'(DEPTH); i++) begin
        slot_pc[i]    <= 64'd0;
        slot_instr[i] <= 32'd0;
      end
    end else if (redirect_valid) begin
      // Flush wins over any push or pop this cycle
      fetch_pc  <= redirect_pc;
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      stopped_q <= 1'b0;
      halted_q  <= 1'b0;
    end else begin
      if (push_c) begin
        slot_pc[wr_ptr]    <= fetch_pc;
        slot_instr[wr_ptr] <= imem_rdata;
        wr_ptr             <= wr_ptr + PW'(1);
        fetch_pc           <= fetch_pc + 64'd4;
        if (is_halt(imem_rdata)) stopped_q <= 1'b1;
      end
      if (pop_c) begin
        rd_ptr <= rd_ptr + PW'(1);
        if (is_halt(id_instr)) halted_q <= 1'b1;
      end
      if (push_c && !pop_c)      count <= count + CW'(1);
      else if (pop_c && !push_c) count <= count - CW'(1);
    end
  end

endmodule

// File: doc/tinker_fetch_unit.md
# tinker_fetch_unit

Instruction fetch stage for the pipelined Tinker core. It owns the fetch PC, reads 32-bit instruction words from the unified memory's combinational instruction port, and buffers them with their PCs in a small prefetch FIFO. The FIFO feeds the IF/ID boundary through a valid/ready handshake. The unit also stops fetching at a halt instruction and flushes and redirects when the execute stage resolves a taken branch, jump, call or return.

## Interface
- DEPTH, 4, prefetch FIFO entries; power of two, ≥2
- RESET_PC, 64'h2000, fetch PC after reset
- clk  input  1  clock; all state updates on posedge
- reset  input  1  synchronous, active-high
- redirect_valid  input  1  taken control transfer resolved downstream; flush and refetch
- redirect_pc  input  64  new fetch PC, sampled when redirect_valid=1
- imem_addr  output  64  byte address to memory instruction port; always equals fetch_pc
- imem_rdata  input  32  little-endian word at imem_addr, valid in the same cycle (combinational read)
- imem_ready  input  1  memory port available this cycle; 0 blocks the push
- id_valid  output  1  head entry presented to decode
- id_pc  output  64  PC of head entry
- id_instr  output  32  instruction of head entry
- id_ready  input  1  decode accepts head this cycle
- fetch_stopped  output  1  a halt word has been enqueued; no further fetch
- halted  output  1  a halt word has been accepted by decode
- occupancy  output  $clog2(DEPTH)+1  current FIFO count

## Operation
- Halt word: imem_rdata[31:27]==5'h0f and imem_rdata[3:0]==4'h0. The same test is applied to a popped entry's id_instr.
- pop = id_valid & id_ready.
- push = !redirect_valid & !fetch_stopped & imem_ready & (occupancy<DEPTH | pop).
- On push, write {fetch_pc, imem_rdata} at the write pointer, advance the write pointer and set fetch_pc <= fetch_pc+4.
- If the pushed word is a halt word, set fetch_stopped.
- On pop, advance the read pointer. If the popped id_instr is a halt word, set halted.
- occupancy updates +1 on push only, −1 on pop only, and is unchanged when both or neither occur.
- Pointers are $clog2(DEPTH) bits and wrap modulo DEPTH. A push when full is legal only with a simultaneous pop; the write pointer then reaches the slot the read pointer just vacated.
- fetch_pc arithmetic is 64-bit unsigned and wraps from 2^64−4 to 0. No alignment check is done.
- Redirect has priority over everything:
  - id_valid is forced to 0 combinationally while redirect_valid=1, so no pop occurs.
  - Next edge: occupancy=0, both pointers=0, fetch_pc=redirect_pc, fetch_stopped=0, halted=0.
  - No push occurs in the redirect cycle.
- id_valid = (occupancy!=0) & !redirect_valid.
- id_pc and id_instr show the head slot when occupancy!=0 and are driven to 0 when the FIFO is empty.

## Timing
- Reset (sync): fetch_pc=RESET_PC, imem_addr=RESET_PC, occupancy=0, pointers=0, all storage=0, id_valid=0, id_pc=0, id_instr=0, fetch_stopped=0, halted=0.
- Reset asserted mid-operation discards all entries and any pending redirect at that edge.
- Latency: a word pushed at edge N is on id_* with id_valid=1 after edge N. This gives 1 cycle from imem_addr to decode.
- The first instruction after reset deasserts appears after the first active edge.
- Throughput: 1 instruction per cycle while imem_ready=1 and decode accepts every cycle. Occupancy stays at 1.
- Full FIFO with id_ready=0 stalls fetch. imem_addr holds and no word is lost or duplicated.
- The cycle after a redirect edge: id_valid=0 and imem_addr=redirect_pc. The first redirected word reaches decode one edge later.
- halted rises the cycle after the pop edge of the halt entry. fetch_stopped rises the cycle after the push edge of the halt word.

## Test plan
- Reset then stream, id_ready=1, imem_ready=1, memory holds words at 0x2000+4k: id_pc=0x2000,0x2004,0x2008 on consecutive cycles, occupancy=1 steady, imem_addr leads id_pc by 4.
- Backpressure: id_ready=0 for 6 cycles: occupancy climbs 1..4 then holds, imem_addr holds at 0x2010. After id_ready=1, entries 0x2000..0x200C drain in order with no gap or duplicate.
- Full with simultaneous push/pop: occupancy=4, id_ready=1, imem_ready=1 each cycle: occupancy stays 4, and pointer wrap preserves PC order over ≥10 cycles.
- Redirect: with 3 entries queued, redirect_valid=1, redirect_pc=0x3000 for one cycle: id_valid=0 that cycle, occupancy=0 next cycle, then id_pc=0x3000 followed by 0x3004.
- Halt: word 0x78000000 at 0x2008: fetch_stopped=1 after its push, and imem_addr frozen at 0x200C. halted=1 the cycle after decode accepts id_pc=0x2008. A later redirect to 0x2100 clears both and resumes fetch.
- imem_ready=0 for 2 cycles and a reset pulse mid-stream: no push while not ready. Reset returns all outputs to reset values, and the next fetch is from 0x2000.
